// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared funct3 codes, FSM states and exception codes for the MEM-stage LSU
package mem_lsu_pkg;
  typedef enum logic [2:0] {
    OP_B  = 3'b000,
    OP_H  = 3'b001,
    OP_W  = 3'b010,
    OP_BU = 3'b100,
    OP_HU = 3'b101
  } mem_op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_t;
  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_MISAL = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: req/gnt/rvalid data bus between the LSU (master) and memory (slave)
interface mem_lsu_if;
  logic req, we, gnt, rvalid;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] be;
  modport master(output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: store lane steering/byte enables, load extract/extend and alignment check
module mem_lsu_align import mem_lsu_pkg::*; (
  input  logic [1:0]  lane,
  input  logic [2:0]  op,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic        aligned,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [3:0]  be
);
  logic is_b, is_h;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  always_comb begin
    is_b = mem_op_t'({1'b0, op[1:0]}) == OP_B;
    is_h = mem_op_t'({1'b0, op[1:0]}) == OP_H;
    aligned = is_b | (is_h ? !lane[0] : lane == 2'b00);
    wdata = is_b ? {4{sdata[7:0]}} : is_h ? {2{sdata[15:0]}} : sdata;
    be = is_b ? 4'b0001 << lane : is_h ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    byte_sel = 8'(rdata >> {lane, 3'b000});
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    ldata = is_b ? {{24{byte_sel[7] & !op[2]}}, byte_sel}
          : is_h ? {{16{half_sel[15] & !op[2]}}, half_sel} : rdata;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving a req/gnt/rvalid bus and the MEM/WB register
module mem_lsu import mem_lsu_pkg::*; #(
  parameter int TIMEOUT = 255,
  parameter int CW = 8
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        ex2mem_wr_reg_ffout,
  input  logic [4:0]  ex2mem_wr_regindex_ffout,
  input  logic [31:0] ex2mem_wr_wdata_ffout,
  input  logic [31:0] ex2mem_memaddr_ffout,
  input  logic [31:0] ex2mem_wr_memwdata_ffout,
  input  logic [2:0]  ex2mem_mem_op_ffout,
  input  logic        ex2mem_load_ffout,
  input  logic        ex2mem_store_ffout,
  mem_lsu_if.master   dbus,
  output logic        mem_stall,
  output logic        mem2wb_wr_reg,
  output logic [4:0]  mem2wb_wr_regindex,
  output logic [31:0] mem2wb_wr_wdata,
  output logic [1:0]  mem2wb_exc,
  output logic [31:0] mem2wb_badaddr
);
  state_t state;
  logic [CW-1:0] cnt;
  logic access, aligned, go, done, tmo, wr_ok;
  logic [31:0] st_data, ld_data;
  logic [3:0] be;
  logic [1:0] exc_nx;
  mem_lsu_align u_align (
    .lane(ex2mem_memaddr_ffout[1:0]), .op(ex2mem_mem_op_ffout),
    .sdata(ex2mem_wr_memwdata_ffout), .rdata(dbus.rdata),
    .aligned(aligned), .wdata(st_data), .ldata(ld_data), .be(be)
  );
  // go is gated by cpurst so the request drops the instant reset asserts
  always_comb begin
    access = ex2mem_load_ffout | ex2mem_store_ffout;
    go = state == ST_IDLE & access & aligned & !cpurst;
    done = state == ST_RSP & dbus.rvalid;
    tmo = (TIMEOUT != 0) & state != ST_IDLE & !done & cnt == CW'(TIMEOUT - 1);
    dbus.req = go | state == ST_REQ;
    dbus.we = dbus.req & !ex2mem_load_ffout;
    dbus.addr = dbus.req ? {ex2mem_memaddr_ffout[31:2], 2'b00} : '0;
    dbus.wdata = dbus.req ? st_data : '0;
    dbus.be = dbus.req ? be : '0;
    mem_stall = go | (state != ST_IDLE & !done & !tmo);
    wr_ok = !mem_stall & (!access | (ex2mem_load_ffout & aligned & !tmo));
    exc_nx = (mem_stall | !access) ? EXC_NONE : !aligned ? EXC_MISAL : tmo ? EXC_TIMEOUT : EXC_NONE;
  end
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      state <= ST_IDLE;
      cnt <= '0;
      mem2wb_wr_reg <= 1'b0;
      mem2wb_wr_regindex <= '0;
      mem2wb_wr_wdata <= '0;
      mem2wb_exc <= EXC_NONE;
      mem2wb_badaddr <= '0;
    end else begin
      cnt <= state == ST_IDLE ? '0 : cnt + 1'b1;
      state <= (done | tmo) ? ST_IDLE : dbus.req ? (dbus.gnt ? ST_RSP : ST_REQ) : state;
      mem2wb_wr_reg <= wr_ok & ex2mem_wr_reg_ffout;
      mem2wb_wr_regindex <= wr_ok ? ex2mem_wr_regindex_ffout : '0;
      mem2wb_wr_wdata <= !wr_ok ? '0 : access ? ld_data : ex2mem_wr_wdata_ffout;
      mem2wb_exc <= exc_nx;
      mem2wb_badaddr <= exc_nx != EXC_NONE ? ex2mem_memaddr_ffout : '0;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and randomized checks of mem_lsu against a transaction-level model
module tb_mem_lsu;
  localparam int TO = 4;
  typedef struct packed {
    logic wr;
    logic [4:0] idx;
    logic [31:0] data;
    logic [1:0] exc;
    logic [31:0] bad;
    logic full;
  } wb_t;
  logic clk = 1'b0, cpurst = 1'b1;
  logic ex_wr = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
  logic [4:0] ex_idx = '0;
  logic [31:0] ex_wdata = '0, ex_addr = '0, ex_sdata = '0;
  logic [2:0] ex_op = '0;
  logic stall, wb_wr;
  logic [4:0] wb_idx;
  logic [31:0] wb_data, wb_bad;
  logic [1:0] wb_exc;
  logic e_req, e_we, e_stall;
  logic [31:0] e_addr, e_wdata;
  logic [3:0] e_be;
  wb_t e_wb, pend;
  bit chk = 0, wb_chk = 0;
  int tests = 0, fails = 0;
  mem_lsu_if dbus();
  mem_lsu #(.TIMEOUT(TO), .CW(8)) dut (
    .clk(clk), .cpurst(cpurst),
    .ex2mem_wr_reg_ffout(ex_wr), .ex2mem_wr_regindex_ffout(ex_idx),
    .ex2mem_wr_wdata_ffout(ex_wdata), .ex2mem_memaddr_ffout(ex_addr),
    .ex2mem_wr_memwdata_ffout(ex_sdata), .ex2mem_mem_op_ffout(ex_op),
    .ex2mem_load_ffout(ex_load), .ex2mem_store_ffout(ex_store),
    .dbus(dbus), .mem_stall(stall),
    .mem2wb_wr_reg(wb_wr), .mem2wb_wr_regindex(wb_idx), .mem2wb_wr_wdata(wb_data),
    .mem2wb_exc(wb_exc), .mem2wb_badaddr(wb_bad)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (chk) begin
      check("dbus_req", dbus.req, e_req);
      check("dbus_we", dbus.we, e_we);
      check("dbus_addr", dbus.addr, e_addr);
      check("dbus_wdata", dbus.wdata, e_wdata);
      check("dbus_be", dbus.be, e_be);
      check("mem_stall", stall, e_stall);
    end
    if (wb_chk) begin
      check("wb_wr_reg", wb_wr, e_wb.wr);
      check("wb_exc", wb_exc, e_wb.exc);
      check("wb_badaddr", wb_bad, e_wb.bad);
      if (e_wb.full) begin
        check("wb_regindex", wb_idx, e_wb.idx);
        check("wb_wdata", wb_data, e_wb.data);
      end
    end
  end
  // n = cycles since the instruction entered MEM; granted = bus accepted the request earlier
  task automatic model_cycle(input int n, input bit granted, input logic g, input logic rv,
                             input logic [31:0] rdat, output bit gr_next);
    int sz, off;
    bit acc, al, done, to;
    longint v;
    sz = ex_op[1:0] == 2'd0 ? 1 : ex_op[1:0] == 2'd1 ? 2 : 4;
    off = int'(ex_addr % 4);
    acc = ex_load | ex_store;
    al = (ex_addr % sz) == 0;
    {e_req, e_we, e_addr, e_wdata, e_be, e_stall} = '0;
    pend = '0;
    pend.full = 1'b1;
    gr_next = granted;
    if (!acc) begin
      pend.wr = ex_wr;
      pend.idx = ex_idx;
      pend.data = ex_wdata;
    end else if (!al) begin
      pend.exc = 2'd1;
      pend.bad = ex_addr;
      pend.full = 1'b0;
    end else begin
      done = granted && rv;
      to = n >= 1 && n == TO && !done;
      e_req = !granted;
      e_stall = !(done || to);
      if (e_req) begin
        e_we = !ex_load;
        e_addr = ex_addr & ~32'd3;
        for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = ex_sdata[8*(i % sz) +: 8];
        e_be = 4'((1 << sz) - 1) << off;
      end
      gr_next = granted || (e_req && g);
      if (to) begin
        pend.exc = 2'd2;
        pend.bad = ex_addr;
        pend.full = 1'b0;
      end else if (done && ex_load) begin
        v = longint'(rdat >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
        if (sz < 4 && !ex_op[2] && v >= (64'd1 << (8 * sz - 1))) v -= (64'd1 << (8 * sz));
        pend.wr = ex_wr;
        pend.idx = ex_idx;
        pend.data = v[31:0];
      end else if (done) pend.full = 1'b0;
    end
  endtask
  // gd<0: random bus; else gnt from cycle gd onward, rvalid held at rv_always
  task automatic run_ins(input logic wr, input logic [4:0] idx, input logic [31:0] wd,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [2:0] op,
                         input logic ld, input logic st, input int gd, input bit rv_always,
                         input logic [31:0] rd, output int stalls);
    bit granted, gr, last;
    logic g, rv;
    logic [31:0] rdat;
    {ex_wr, ex_idx, ex_wdata, ex_addr, ex_sdata, ex_op, ex_load, ex_store} = {wr, idx, wd, addr, sd, op, ld, st};
    granted = 0;
    stalls = 0;
    for (int n = 0; n < 64; n++) begin
      if (gd < 0) begin
        g = $urandom_range(0, 3) != 0;
        rv = $urandom_range(0, 3) != 0;
        rdat = $urandom;
      end else begin
        g = n >= gd;
        rv = rv_always;
        rdat = rd;
      end
      dbus.gnt = g;
      dbus.rvalid = rv;
      dbus.rdata = rdat;
      model_cycle(n, granted, g, rv, rdat, gr);
      chk = 1;
      last = e_stall;
      @(posedge clk);
      #1;
      e_wb = pend;
      wb_chk = 1;
      granted = gr;
      if (!last) break;
      stalls++;
    end
  endtask
  initial begin
    int s;
    logic [1:0] kind;
    dbus.gnt = 0;
    dbus.rvalid = 0;
    dbus.rdata = '0;
    #2;
    check("rst_req", dbus.req, 0);
    check("rst_stall", stall, 0);
    check("rst_wb_wr", wb_wr, 0);
    check("rst_wb_data", wb_data, 0);
    @(posedge clk);
    #1 cpurst = 0;
    run_ins(1, 5, 0, 32'h100, 0, 3'b010, 1, 0, 0, 1, 32'hDEADBEEF, s);
    check("lw_stalls", s, 1);
    check("lw_data", wb_data, 32'hDEADBEEF);
    check("lw_wr", wb_wr, 1);
    check("lw_idx", wb_idx, 5);
    run_ins(1, 6, 0, 32'h103, 0, 3'b000, 1, 0, 0, 1, 32'h80FFFF7F, s);
    check("lb_data", wb_data, 32'hFFFFFF80);
    run_ins(1, 6, 0, 32'h103, 0, 3'b100, 1, 0, 0, 1, 32'h80FFFF7F, s);
    check("lbu_data", wb_data, 32'h00000080);
    run_ins(1, 6, 0, 32'h102, 0, 3'b101, 1, 0, 0, 1, 32'h80FFFF7F, s);
    check("lhu_data", wb_data, 32'h000080FF);
    run_ins(1, 8, 0, 32'h202, 32'h1234ABCD, 3'b001, 0, 1, 3, 1, 0, s);
    check("sh_stalls", s, 4);
    check("sh_wr", wb_wr, 0);
    check("sh_exc", wb_exc, 0);
    run_ins(1, 9, 0, 32'h101, 0, 3'b010, 1, 0, 0, 1, 0, s);
    check("mis_stalls", s, 0);
    check("mis_exc", wb_exc, 1);
    check("mis_bad", wb_bad, 32'h101);
    check("mis_wr", wb_wr, 0);
    run_ins(1, 10, 0, 32'h300, 0, 3'b010, 1, 0, 1000, 1, 0, s);
    check("to_stalls", s, 4);
    check("to_exc", wb_exc, 2);
    check("to_bad", wb_bad, 32'h300);
    check("to_wr", wb_wr, 0);
    run_ins(1, 7, 32'hCAFEF00D, 32'h300, 0, 3'b010, 0, 0, 1000, 1, 0, s);
    check("alu_stalls", s, 0);
    check("alu_data", wb_data, 32'hCAFEF00D);
    check("alu_idx", wb_idx, 7);
    {ex_wr, ex_idx, ex_addr, ex_op, ex_load, ex_store} = {1'b1, 5'd9, 32'h400, 3'b010, 1'b1, 1'b0};
    dbus.gnt = 1;
    dbus.rvalid = 0;
    chk = 0;
    wb_chk = 0;
    @(posedge clk);
    #1;
    dbus.gnt = 0;
    dbus.rvalid = 1;
    #2 cpurst = 1;
    #1;
    check("rsp_rst_req", dbus.req, 0);
    check("rsp_rst_stall", stall, 0);
    check("rsp_rst_wb_wr", wb_wr, 0);
    check("rsp_rst_wb_data", wb_data, 0);
    @(posedge clk);
    #1 cpurst = 0;
    run_ins(1, 9, 0, 32'h400, 0, 3'b010, 1, 0, 1, 1, 32'h11223344, s);
    check("post_rst_stalls", s, 2);
    check("post_rst_data", wb_data, 32'h11223344);
    check("post_rst_wr", wb_wr, 1);
    for (int i = 0; i < 400; i++) begin
      kind = 2'($urandom_range(0, 3));
      run_ins(1'($urandom), 5'($urandom), $urandom, $urandom, $urandom, 3'($urandom),
              kind[0], kind[1], -1, 0, 0, s);
    end
    run_ins(1, 3, 32'h5A5A5A5A, 0, 0, 3'b010, 0, 0, 1000, 0, 0, s);
    check("alu2_data", wb_data, 32'h5A5A5A5A);
    chk = 0;
    wb_chk = 0;
    #2 cpurst = 1;
    #1;
    check("rst2_wb_data", wb_data, 0);
    check("rst2_wb_wr", wb_wr, 0);
    check("rst2_wb_idx", wb_idx, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
